scan_reg_bank: RTL and testbench

//  Parametrised WIDTH-bit register bank built on the scan-flop concept: functional parallel load,

---
 rtl/scan_reg_bank_if.sv | 37 +++
 rtl/scan_reg_bank.sv | 99 +++++++++
 tb/tb_scan_reg_bank.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/scan_reg_bank_if.sv
// Bundles the data and control/status signals of one scan_reg_bank instance.
// Latency: none, wiring only.
// Backpressure: none; the bank never stalls its driver.
//
// Ports grouped here:
//   d, load     functional parallel load (driven by datapath)
//   se, si      manual single-step scan shift (driven by scan controller)
//   start       auto capture/unload request, level sampled
//   q, so       register contents and scan-out (so = q MSB)
//   busy, done  sequencer status; shift_cnt counts shifts in the current sequence
interface scan_reg_bank_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] d;
  logic             load;
  logic             se;
  logic             si;
  logic             start;
  logic [WIDTH-1:0] q;
  logic             so;
  logic             busy;
  logic             done;
  logic [CW-1:0]    shift_cnt;

  // master drives the bank; slave is the bank itself
  modport master (
    output d, load, se, si, start,
    input  q, so, busy, done, shift_cnt
  );

  modport slave (
    input  d, load, se, si, start,
    output q, so, busy, done, shift_cnt
  );
endinterface

// File: rtl/scan_reg_bank.sv
// Scan-flop register bank: parallel load, manual scan shift, self-timed capture/unload.
// Latency: CAPTURE=1 -> done in the cycle after edge WIDTH+1 from start; CAPTURE=0 one cycle less.
// Backpressure: none; start is level sampled in IDLE only, ignored while busy/done or when se=1.
//
// Ports:
//   clock    rising-edge clock
//   reset_l  synchronous active-low reset
//   bus      scan_reg_bank_if.slave: d/load/se/si/start in, q/so/busy/done/shift_cnt out
module scan_reg_bank #(
  parameter int WIDTH   = 8,
  parameter int CAPTURE = 1,
  parameter int CW      = $clog2(WIDTH + 1)
) (
  input  logic                clock,
  input  logic                reset_l,
  scan_reg_bank_if.slave      bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] q_shifted;

  // MSB leaves on so, si enters at bit 0
  assign q_shifted = {q_reg[WIDTH-2:0], bus.si};

  always_ff @(posedge clock) begin
    if (!reset_l) begin
      state <= ST_IDLE;
      q_reg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      q_reg <= q_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q_reg;
    cnt_nxt   = cnt;

    case (state)
      ST_IDLE: begin
        if (bus.se) begin
          q_nxt = q_shifted;
        end else if (bus.load) begin
          q_nxt = bus.d;
        end
        // A start coinciding with se is dropped, not queued.
        if (bus.start && !bus.se) begin
          state_nxt = (CAPTURE != 0) ? ST_CAPTURE : ST_SHIFT;
          cnt_nxt   = '0;
        end
      end

      ST_CAPTURE: begin
        q_nxt     = bus.d;
        state_nxt = ST_SHIFT;
      end

      ST_SHIFT: begin
        q_nxt   = q_shifted;
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        // q and shift_cnt hold; shift_cnt clears on the next accepted start
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Status outputs are pure decodes of the state register, so busy and done are mutually exclusive.
  assign bus.q         = q_reg;
  assign bus.so        = q_reg[WIDTH-1];
  assign bus.busy      = (state == ST_CAPTURE) || (state == ST_SHIFT);
  assign bus.done      = (state == ST_DONE);
  assign bus.shift_cnt = cnt;

endmodule

// File: tb/tb_scan_reg_bank.sv
// Bench for scan_reg_bank: one instance with CAPTURE=1 and one with CAPTURE=0 share all stimulus.
// Each cycle both are compared against a sequence-timeline reference model after the clock edge.
// Directed scenarios are followed by a randomized phase.
module tb_scan_reg_bank;
  localparam int W = 8;

  logic       clock;
  logic       reset_l;
  logic [7:0] d;
  logic       load, se, si, start;

  int n_checks = 0;
  int n_errors = 0;

  scan_reg_bank_if #(.WIDTH(W)) bus_c1 ();
  scan_reg_bank_if #(.WIDTH(W)) bus_c0 ();

  assign bus_c1.d = d;  assign bus_c1.load = load;  assign bus_c1.se = se;
  assign bus_c1.si = si; assign bus_c1.start = start;
  assign bus_c0.d = d;  assign bus_c0.load = load;  assign bus_c0.se = se;
  assign bus_c0.si = si; assign bus_c0.start = start;

  scan_reg_bank #(.WIDTH(W), .CAPTURE(1)) dut_c1 (.clock(clock), .reset_l(reset_l), .bus(bus_c1));
  scan_reg_bank #(.WIDTH(W), .CAPTURE(0)) dut_c0 (.clock(clock), .reset_l(reset_l), .bus(bus_c0));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model, index 0 = CAPTURE=1, index 1 = CAPTURE=0.
  // pos = edges elapsed since the accepted start (-1 when no sequence is running).
  int         mpos[2];
  int         mcnt[2];
  logic [7:0] mq[2];

  function automatic int first_shift(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic int last_shift(input int k);
    return W + first_shift(k) - 1;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input int k);
    if (!reset_l) begin
      mq[k] = 8'h00; mpos[k] = -1; mcnt[k] = 0;
    end else if (mpos[k] >= 0) begin
      mpos[k]++;
      if (mpos[k] > last_shift(k)) begin
        mpos[k] = -1;                        // leaving the done cycle, inputs ignored
      end else if (k == 0 && mpos[k] == 1) begin
        mq[k] = d;                           // capture edge
      end else begin
        mq[k] = {mq[k][6:0], si};
        mcnt[k] = mpos[k] - first_shift(k) + 1;
      end
    end else begin
      if (se) mq[k] = {mq[k][6:0], si};
      else if (load) mq[k] = d;
      if (start && !se) begin
        mpos[k] = 0; mcnt[k] = 0;
      end
    end
  endtask

  // One clock edge: update the model with the inputs present at the edge, then compare 1 time unit later.
  task automatic cyc();
    int exp_busy, exp_done;
    @(posedge clock);
    model_edge(0);
    model_edge(1);
    #1;
    exp_busy = (mpos[0] >= 0 && mpos[0] < last_shift(0)) ? 1 : 0;
    exp_done = (mpos[0] == last_shift(0)) ? 1 : 0;
    chk("c1_q",    int'(bus_c1.q),         int'(mq[0]));
    chk("c1_so",   int'(bus_c1.so),        int'(mq[0][7]));
    chk("c1_busy", int'(bus_c1.busy),      exp_busy);
    chk("c1_done", int'(bus_c1.done),      exp_done);
    chk("c1_cnt",  int'(bus_c1.shift_cnt), mcnt[0]);
    exp_busy = (mpos[1] >= 0 && mpos[1] < last_shift(1)) ? 1 : 0;
    exp_done = (mpos[1] == last_shift(1)) ? 1 : 0;
    chk("c0_q",    int'(bus_c0.q),         int'(mq[1]));
    chk("c0_so",   int'(bus_c0.so),        int'(mq[1][7]));
    chk("c0_busy", int'(bus_c0.busy),      exp_busy);
    chk("c0_done", int'(bus_c0.done),      exp_done);
    chk("c0_cnt",  int'(bus_c0.shift_cnt), mcnt[1]);
  endtask

  task automatic idle_inputs();
    load = 1'b0; se = 1'b0; si = 1'b0; start = 1'b0;
  endtask

  // Capture/unload of 3C with si=1 on the CAPTURE=1 bank; optional mid-shift noise on the controls.
  task automatic run_capture_seq(input bit noisy);
    logic [7:0] so_pat;
    int         busy_cycles;
    int         done_at;
    so_pat = 8'b0011_1100;
    busy_cycles = 0;
    done_at = -1;
    idle_inputs();
    load = 1'b1; d = 8'h00;
    cyc();
    load = 1'b0; d = 8'h3C; si = 1'b1; start = 1'b1;
    for (int e = 0; e <= 11; e++) begin
      cyc();                                        // edge e relative to start
      start = 1'b0;
      if (noisy && e >= 3 && e <= 5) begin
        start = 1'b1; load = 1'b1; se = 1'b1; d = 8'h00;
      end else begin
        load = 1'b0; se = 1'b0; d = 8'h3C;
      end
      if (bus_c1.busy) busy_cycles++;
      if (bus_c1.done && done_at < 0) done_at = e + 1;  // cycle number after the start edge
      if (e >= 1 && e <= 8) chk("t3_so", int'(bus_c1.so), int'(so_pat[8 - e]));
      if (e == 9) begin
        chk("t3_final_q", int'(bus_c1.q), 8'hFF);
        chk("t3_final_cnt", int'(bus_c1.shift_cnt), 8);
      end
    end
    chk("t3_busy_cycles", busy_cycles, 9);
    chk("t3_done_cycle", done_at, 10);
    idle_inputs();
  endtask

  initial begin
    int done_seen;
    logic [7:0] exp_q_seq[4];
    logic [7:0] so6;
    d = 8'hFF; idle_inputs();
    mpos[0] = -1; mpos[1] = -1; mcnt[0] = 0; mcnt[1] = 0; mq[0] = 8'h00; mq[1] = 8'h00;

    // 1: reset dominates a simultaneous load
    reset_l = 1'b0; load = 1'b1;
    cyc(); cyc();
    chk("t1_q", int'(bus_c1.q), 0);
    chk("t1_so", int'(bus_c1.so), 0);
    chk("t1_busy", int'(bus_c1.busy), 0);
    chk("t1_done", int'(bus_c1.done), 0);
    chk("t1_cnt", int'(bus_c1.shift_cnt), 0);
    reset_l = 1'b1; load = 1'b0;
    cyc();

    // 2: parallel load then three manual shifts
    exp_q_seq[0] = 8'hA5; exp_q_seq[1] = 8'h4A; exp_q_seq[2] = 8'h94; exp_q_seq[3] = 8'h28;
    load = 1'b1; d = 8'hA5;
    cyc();
    chk("t2_q0", int'(bus_c1.q), int'(exp_q_seq[0]));
    chk("t2_so0", int'(bus_c1.so), int'(exp_q_seq[0][7]));
    load = 1'b0; se = 1'b1; si = 1'b0;
    for (int i = 1; i < 4; i++) begin
      cyc();
      chk("t2_q", int'(bus_c1.q), int'(exp_q_seq[i]));
      chk("t2_so", int'(bus_c1.so), int'(exp_q_seq[i][7]));
    end
    idle_inputs();

    // 3 and 4: clean sequence, then the same with controls toggled mid-shift
    run_capture_seq(1'b0);
    run_capture_seq(1'b1);

    // 5: reset on the 4th shift edge aborts the sequence without a done pulse
    load = 1'b1; d = 8'h5A;
    cyc();
    load = 1'b0; start = 1'b1; si = 1'b1;
    cyc();                                          // edge 0
    start = 1'b0;
    for (int e = 1; e <= 4; e++) cyc();             // capture edge, shifts 1..3
    reset_l = 1'b0;
    cyc();                                          // 4th shift edge under reset
    chk("t5_q", int'(bus_c1.q), 0);
    chk("t5_busy", int'(bus_c1.busy), 0);
    chk("t5_cnt", int'(bus_c1.shift_cnt), 0);
    reset_l = 1'b1;
    done_seen = 0;
    for (int e = 0; e < 12; e++) begin
      cyc();
      if (bus_c1.done || bus_c0.done) done_seen = 1;
    end
    chk("t5_no_done", done_seen, 0);

    // 6: CAPTURE=0 bank unloads its current contents
    so6 = 8'b1000_0001;
    idle_inputs();
    load = 1'b1; d = 8'h81;
    cyc();
    load = 1'b0; si = 1'b0; start = 1'b1; d = 8'hC3;
    for (int e = 0; e <= 8; e++) begin
      cyc();
      start = 1'b0;
      if (e <= 7) chk("t6_so", int'(bus_c0.so), int'(so6[7 - e]));
      if (e == 7) chk("t6_done_early", int'(bus_c0.done), 0);
      if (e == 8) begin
        chk("t6_done", int'(bus_c0.done), 1);
        chk("t6_q", int'(bus_c0.q), 0);
        chk("t6_cnt", int'(bus_c0.shift_cnt), 8);
      end
    end
    idle_inputs();
    cyc();

    // Randomized phase: model checks every cycle
    for (int i = 0; i < 400; i++) begin
      d       = 8'($urandom);
      load    = ($urandom_range(0, 2) == 0);
      se      = ($urandom_range(0, 4) == 0);
      si      = 1'($urandom);
      start   = ($urandom_range(0, 5) == 0);
      reset_l = ($urandom_range(0, 60) != 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
